// File: rtl/fwc_pkg.sv
// fwc_pkg: shared definitions for the frame window controller.
//   - fwc_state_e : frame sequencing FSM states (IDLE, RUN)
//   - FWC_*       : default counter width and default frame geometry
package fwc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fwc_state_e;

    localparam int unsigned FWC_COUNT_W  = 13;
    localparam int unsigned FWC_ACT_COLS = 800;
    localparam int unsigned FWC_ACT_ROWS = 600;
    localparam int unsigned FWC_TOT_COLS = 901;
    localparam int unsigned FWC_TOT_ROWS = 701;

endpackage : fwc_pkg

// File: rtl/frame_window_ctrl_raster_counter.sv
// raster_counter: row/column position counter over a TOT_ROWS x TOT_COLS frame.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-low reset
//   advance_i   in   step the position by one beat
//   clear_i     in   force position back to (0,0)
//   row_o       out  current line index
//   col_o       out  current column index
//   last_beat_o out  position is the final beat of the frame
module raster_counter
    import fwc_pkg::*;
#(
    parameter int unsigned TOT_COLS = FWC_TOT_COLS,
    parameter int unsigned TOT_ROWS = FWC_TOT_ROWS,
    parameter int unsigned COUNT_W  = FWC_COUNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               advance_i,
    input  logic               clear_i,
    output logic [COUNT_W-1:0] row_o,
    output logic [COUNT_W-1:0] col_o,
    output logic               last_beat_o
);

    logic [COUNT_W-1:0] row_q, row_d;
    logic [COUNT_W-1:0] col_q, col_d;
    logic               last_col;
    logic               last_row;

    assign last_col = (col_q == COUNT_W'(TOT_COLS - 1));
    assign last_row = (row_q == COUNT_W'(TOT_ROWS - 1));

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear_i) begin
            row_d = '0;
            col_d = '0;
        end else if (advance_i) begin
            if (last_col) begin
                col_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o       = row_q;
    assign col_o       = col_q;
    assign last_beat_o = last_col && last_row;

endmodule : raster_counter

// File: rtl/frame_window_ctrl.sv
// frame_window_ctrl: raster sequencer and flow controller for the pixel stream
// entering the feature pipeline. Walks a TOT_ROWS x TOT_COLS frame, forwards
// the ACT_ROWS x ACT_COLS active window through a one-stage output register,
// and sinks blanking beats.
// Optional feature: define FWC_DROP_COUNT_EN to add the drop_count output
// (saturating count of accepted blanking beats since the last frame start).
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-low reset
//   start       in   begin a frame (IDLE only)
//   continuous  in   restart at frame end instead of returning to IDLE
//   in_pixel    in   upstream pixel
//   in_valid    in   upstream beat valid
//   in_ready    out  upstream beat accepted (combinational)
//   out_pixel   out  registered active-window pixel
//   out_valid   out  out_pixel valid
//   out_ready   in   downstream accepts out_pixel
//   row         out  line index of next beat
//   col         out  column index of next beat
//   frame_done  out  one-cycle pulse after the last beat of a frame
//   busy        out  FSM not in IDLE
//   drop_count  out  (FWC_DROP_COUNT_EN only) accepted blanking beats
module frame_window_ctrl
    import fwc_pkg::*;
#(
    parameter int unsigned ACT_COLS = FWC_ACT_COLS,
    parameter int unsigned ACT_ROWS = FWC_ACT_ROWS,
    parameter int unsigned TOT_COLS = FWC_TOT_COLS,
    parameter int unsigned TOT_ROWS = FWC_TOT_ROWS,
    parameter int unsigned COUNT_W  = FWC_COUNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               continuous,
    input  logic [7:0]         in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [7:0]         out_pixel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] row,
    output logic [COUNT_W-1:0] col,
    output logic               frame_done,
    output logic               busy
`ifdef FWC_DROP_COUNT_EN
    ,
    output logic [15:0]        drop_count
`endif
);

    fwc_state_e         state_q, state_d;
    logic [7:0]         pixel_q, pixel_d;
    logic               valid_q, valid_d;
    logic               done_q;
    logic               active;
    logic               accept;
    logic               last_beat;
    logic               run;
    logic [COUNT_W-1:0] row_w;
    logic [COUNT_W-1:0] col_w;

    raster_counter #(
        .TOT_COLS (TOT_COLS),
        .TOT_ROWS (TOT_ROWS),
        .COUNT_W  (COUNT_W)
    ) u_raster (
        .clock       (clock),
        .reset       (reset),
        .advance_i   (accept),
        .clear_i     (!run),
        .row_o       (row_w),
        .col_o       (col_w),
        .last_beat_o (last_beat)
    );

    assign run    = (state_q == RUN);
    assign active = (row_w < COUNT_W'(ACT_ROWS)) && (col_w < COUNT_W'(ACT_COLS));
    // Blanking beats never touch the output register, so they are sunk even
    // while the register is stalled.
    assign in_ready = run && (!active || !valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (accept && last_beat && !continuous) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A refill takes priority over a drain, so drain+refill keeps valid high.
    always_comb begin
        pixel_d = pixel_q;
        valid_d = valid_q;
        if (accept && active) begin
            pixel_d = in_pixel;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            pixel_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
            done_q  <= accept && last_beat;
        end
    end

`ifdef FWC_DROP_COUNT_EN
    logic [15:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (state_q == IDLE && start) begin
            drop_d = '0;
        end else if (accept && !active && drop_q != '1) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`endif

    assign out_pixel  = pixel_q;
    assign out_valid  = valid_q;
    assign row        = row_w;
    assign col        = col_w;
    assign frame_done = done_q;
    assign busy       = run;

endmodule : frame_window_ctrl

// File: tb/tb_frame_window_ctrl.sv
module tb_frame_window_ctrl;

    localparam int AC = 4;
    localparam int AR = 3;
    localparam int TC = 6;
    localparam int TR = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          continuous = 1'b0;
    logic [7:0]    in_pixel = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    out_pixel;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          frame_done;
    logic          busy;
`ifdef FWC_DROP_COUNT_EN
    logic [15:0]   drop_count;
`endif

    frame_window_ctrl #(
        .ACT_COLS (AC),
        .ACT_ROWS (AR),
        .TOT_COLS (TC),
        .TOT_ROWS (TR),
        .COUNT_W  (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_pixel  (out_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .row        (row),
        .col        (col),
        .frame_done (frame_done),
        .busy       (busy)
`ifdef FWC_DROP_COUNT_EN
        ,
        .drop_count (drop_count)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference raster model, advanced only on observed handshakes.
    int m_row, m_col, m_frame, n_acc, n_fd;
    logic rst_drive = 1'b0;
    logic obs_ready, obs_ov, obs_busy, obs_fd, obs_acc;
    logic [7:0] obs_op;
    logic [CW-1:0] obs_row, obs_col;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    function automatic logic [7:0] pix(input int f, input int r, input int c);
        return 8'(f * 64 + r * 16 + c + 1);
    endfunction

    // One clock cycle: drive at negedge, observe 1 time unit later.
    task automatic step(input logic st, input logic v, input logic ordy);
        @(negedge clock);
        obs_row   = row;
        obs_col   = col;
        reset     = rst_drive;
        start     = st;
        in_valid  = v;
        out_ready = ordy;
        in_pixel  = pix(m_frame, m_row, m_col);
        #1;
        obs_ready = in_ready;
        obs_ov    = out_valid;
        obs_op    = out_pixel;
        obs_busy  = busy;
        obs_fd    = frame_done;
        if (obs_fd) n_fd++;
        if (obs_ov && ordy) got.push_back(obs_op);
        obs_acc = v && obs_ready;
        if (obs_acc) begin
            n_acc++;
            if (m_col == TC - 1) begin
                m_col = 0;
                if (m_row == TR - 1) begin
                    m_row = 0;
                    m_frame++;
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic model_clear();
        m_row = 0; m_col = 0; m_frame = 0; n_acc = 0; n_fd = 0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_drive = 1'b0;
        continuous = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_drive = 1'b1;
        model_clear();
    endtask

    task automatic build_exp(input int f);
        for (int r = 0; r < AR; r++)
            for (int c = 0; c < AC; c++)
                exp_q.push_back(pix(f, r, c));
    endtask

    task automatic run_to(input int target, input int budget, input string name);
        int n = 0;
        while (n_acc < target && n < budget) begin
            step(1'b0, 1'b1, 1'b1);
            n++;
        end
        if (n_acc < target) begin
            checks++; errors++;
            $display("FAIL %s timeout: accepted %0d required %0d", name, n_acc, target);
        end
    endtask

    task automatic test_reset();
        rst_drive = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", obs_ready); end
        checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", obs_ov); end
        checks++; if (obs_op !== 8'h00) begin errors++; $display("FAIL reset_out_pixel got %h exp 00", obs_op); end
        checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", obs_busy); end
        checks++; if (obs_fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", obs_fd); end
        checks++; if (row !== '0 || col !== '0) begin errors++; $display("FAIL reset_pos got %0d,%0d exp 0,0", row, col); end
        rst_drive = 1'b1;
        model_clear();
    endtask

    task automatic test_basic_frame();
        do_reset();
        build_exp(0);
        step(1'b1, 1'b1, 1'b1);
        run_to(24, 60, "basic");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        checks++; if (n_acc !== 24) begin errors++; $display("FAIL basic_accepts got %0d exp 24", n_acc); end
        checks++; if (got.size() !== 12) begin errors++; $display("FAIL basic_count got %0d exp 12", got.size()); end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL basic_pix[%0d] got %h exp %h", i, got[i], exp_q[i]); end
        end
        checks++; if (n_fd !== 1) begin errors++; $display("FAIL basic_frame_done got %0d exp 1", n_fd); end
        checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b exp 0", obs_busy); end
        checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL basic_idle_ready got %b exp 0", obs_ready); end
    endtask

    task automatic test_backpressure();
        do_reset();
        build_exp(0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_first_ready got %b exp 1", obs_ready); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0);
            checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b exp 0", obs_ready); end
            checks++; if (obs_row !== 4'd0 || obs_col !== 4'd1) begin errors++; $display("FAIL bp_hold_pos got %0d,%0d exp 0,1", obs_row, obs_col); end
            checks++; if (obs_ov !== 1'b1 || obs_op !== pix(0, 0, 0)) begin errors++; $display("FAIL bp_hold_pix got %b/%h exp 1/%h", obs_ov, obs_op, pix(0, 0, 0)); end
        end
        step(1'b0, 1'b1, 1'b1);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", obs_ready); end
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        // Now at (0,4) with pixel (0,3) held in the output register.
        step(1'b0, 1'b1, 1'b0);
        checks++; if (obs_ready !== 1'b1 || obs_ov !== 1'b1) begin errors++; $display("FAIL bp_blank_ready got %b/%b exp 1/1", obs_ready, obs_ov); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL bp_blank2_ready got %b exp 1", obs_ready); end
        step(1'b0, 1'b1, 1'b0);
        checks++; if (obs_ready !== 1'b0 || obs_row !== 4'd1 || obs_col !== 4'd0) begin errors++; $display("FAIL bp_row1_stall got %b@%0d,%0d exp 0@1,0", obs_ready, obs_row, obs_col); end
        run_to(24, 60, "bp");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        checks++; if (got.size() !== 12) begin errors++; $display("FAIL bp_count got %0d exp 12", got.size()); end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bp_pix[%0d] got %h exp %h", i, got[i], exp_q[i]); end
        end
        checks++; if (n_fd !== 1) begin errors++; $display("FAIL bp_frame_done got %0d exp 1", n_fd); end
    endtask

    task automatic test_continuous();
        int gaps = 0;
        int n = 0;
        int prev;
        do_reset();
        build_exp(0);
        build_exp(1);
        continuous = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        while (n_acc < 48 && n < 120) begin
            if (n_acc >= 30) continuous = 1'b0;
            prev = n_acc;
            step(1'b0, 1'b1, 1'b1);
            if (obs_busy && !obs_acc) gaps++;
            if (prev == 24) begin
                checks++;
                if (obs_row !== 4'd0 || obs_col !== 4'd0 || obs_ready !== 1'b1) begin
                    errors++; $display("FAIL cont_wrap got %0d,%0d rdy %b exp 0,0 rdy 1", obs_row, obs_col, obs_ready);
                end
            end
            n++;
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        checks++; if (n_acc !== 48) begin errors++; $display("FAIL cont_accepts got %0d exp 48", n_acc); end
        checks++; if (gaps !== 0) begin errors++; $display("FAIL cont_gaps got %0d exp 0", gaps); end
        checks++; if (n_fd !== 2) begin errors++; $display("FAIL cont_frame_done got %0d exp 2", n_fd); end
        checks++; if (obs_busy !== 1'b0) begin errors++; $display("FAIL cont_busy_after got %b exp 0", obs_busy); end
        checks++; if (got.size() !== 24) begin errors++; $display("FAIL cont_count got %0d exp 24", got.size()); end
        for (int i = 0; i < 24 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL cont_pix[%0d] got %h exp %h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_bubbles();
        int n = 0;
        int er, ec;
        logic v, r;
        do_reset();
        build_exp(0);
        step(1'b1, 1'b0, 1'b1);
        while (n_acc < 24 && n < 300) begin
            er = m_row;
            ec = m_col;
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            step(1'b0, v, r);
            checks++;
            if (obs_row !== CW'(er) || obs_col !== CW'(ec)) begin
                errors++; $display("FAIL bub_pos got %0d,%0d exp %0d,%0d", obs_row, obs_col, er, ec);
            end
            n++;
        end
        if (n_acc < 24) begin
            checks++; errors++;
            $display("FAIL bub timeout: accepted %0d required 24", n_acc);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        checks++; if (got.size() !== 12) begin errors++; $display("FAIL bub_count got %0d exp 12", got.size()); end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL bub_pix[%0d] got %h exp %h", i, got[i], exp_q[i]); end
        end
        checks++; if (n_fd !== 1) begin errors++; $display("FAIL bub_frame_done got %0d exp 1", n_fd); end
    endtask

    task automatic test_reset_midframe();
        int n = 0;
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        while (!(m_row == 1 && m_col == 2) && n < 40) begin
            step(1'b0, 1'b1, 1'b1);
            n++;
        end
        rst_drive = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        checks++; if (obs_ov !== 1'b1 || obs_row !== 4'd1 || obs_col !== 4'd2) begin errors++; $display("FAIL mid_precond got %b@%0d,%0d exp 1@1,2", obs_ov, obs_row, obs_col); end
        rst_drive = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        checks++; if (obs_ov !== 1'b0) begin errors++; $display("FAIL mid_out_valid got %b exp 0", obs_ov); end
        checks++; if (obs_row !== 4'd0 || obs_col !== 4'd0) begin errors++; $display("FAIL mid_pos got %0d,%0d exp 0,0", obs_row, obs_col); end
        checks++; if (obs_busy !== 1'b0 || obs_ready !== 1'b0) begin errors++; $display("FAIL mid_idle got busy %b rdy %b exp 0/0", obs_busy, obs_ready); end
        model_clear();
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        checks++; if (obs_busy !== 1'b0 || obs_row !== 4'd0 || obs_col !== 4'd0) begin errors++; $display("FAIL mid_needs_start got busy %b @%0d,%0d exp 0@0,0", obs_busy, obs_row, obs_col); end
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        checks++; if (obs_busy !== 1'b1 || obs_ready !== 1'b1) begin errors++; $display("FAIL mid_restart got busy %b rdy %b exp 1/1", obs_busy, obs_ready); end
    endtask

`ifdef FWC_DROP_COUNT_EN
    task automatic test_drop_count();
        do_reset();
        step(1'b1, 1'b1, 1'b1);
        run_to(24, 60, "drop");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        checks++; if (drop_count !== 16'd12) begin errors++; $display("FAIL drop_frame got %0d exp 12", drop_count); end
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL drop_clear got %0d exp 0", drop_count); end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_continuous();
        test_bubbles();
        test_reset_midframe();
`ifdef FWC_DROP_COUNT_EN
        test_drop_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_frame_window_ctrl
